// File: rtl/alu_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: operand width, opcodes, FSM states.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/ALU_Multiplier.sv
// Combinational unsigned array multiplier: Y = A * B as a sum of shifted partial products.
module ALU_Multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Y
);

    always_comb begin
        Y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (B[i]) begin
                Y = Y + ({{WIDTH{1'b0}}, A} << i);
            end
        end
    end

endmodule

// File: rtl/alu_hilo_unit.sv
// Multi-cycle HI/LO multiply/divide unit: magnitude datapath with a final sign-fix cycle.
module alu_hilo_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   dbz_q, dbz_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       a_mag_q, a_mag_d;
    logic [WIDTH-1:0]       b_mag_q, b_mag_d;
    logic                   sa_q, sa_d;
    logic                   sb_q, sb_d;
    logic                   is_div_q, is_div_d;
    // Multiply: full product. Divide: {remainder, quotient/dividend shift register}.
    logic [2*WIDTH-1:0]     res_q, res_d;

    logic                   signed_op;
    logic [WIDTH-1:0]       a_abs, b_abs;
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH:0]         shifted, diff;
    logic [WIDTH-1:0]       rem, quo;
    logic [2*WIDTH-1:0]     neg_res;
    logic [WIDTH-1:0]       neg_rem, neg_quo;

    assign signed_op = (op == OP_MUL) || (op == OP_DIV);
    assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

    ALU_Multiplier #(.WIDTH(WIDTH)) u_mult (
        .A (a_mag_q),
        .B (b_mag_q),
        .Y (prod)
    );

    // Restoring division step: shift in next dividend bit, trial-subtract divisor.
    assign shifted = res_q[2*WIDTH-1:WIDTH-1];
    assign diff    = shifted - {1'b0, b_mag_q};

    assign rem     = res_q[2*WIDTH-1:WIDTH];
    assign quo     = res_q[WIDTH-1:0];
    assign neg_res = -res_q;
    assign neg_rem = -rem;
    assign neg_quo = -quo;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        cnt_d    = cnt_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        is_div_d = is_div_q;
        res_d    = res_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_mag_d  = a_abs;
                    b_mag_d  = b_abs;
                    sa_d     = signed_op && a[WIDTH-1];
                    sb_d     = signed_op && b[WIDTH-1];
                    is_div_d = (op == OP_DIVU) || (op == OP_DIV);
                    dbz_d    = 1'b0;
                    cnt_d    = '0;
                    res_d    = {{WIDTH{1'b0}}, a_abs};
                    busy_d   = 1'b1;
                    state_d  = ((op == OP_DIVU) || (op == OP_DIV)) ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                res_d   = prod;
                state_d = ST_FIX;
            end
            ST_DIV: begin
                if (b_mag_q == '0) begin
                    // Remainder slot keeps |a| so the sign fix restores a as given.
                    res_d   = {a_mag_q, {WIDTH{1'b1}}};
                    dbz_d   = 1'b1;
                    state_d = ST_FIX;
                end else begin
                    if (diff[WIDTH]) begin
                        res_d = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
                    end else begin
                        res_d = {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (is_div_q) begin
                    hi_d = sa_q ? neg_rem : rem;
                    if (dbz_q) begin
                        lo_d = {WIDTH{1'b1}};
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? neg_quo : quo;
                    end
                end else begin
                    {hi_d, lo_d} = (sa_q ^ sb_q) ? neg_res : res_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            is_div_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            cnt_q    <= cnt_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
